// File: rtl/mask_serializer_pkg.sv
// mask_serializer_pkg: shared state encoding for the mask serializer
package mask_serializer_pkg;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/mask_serializer_first_bit_finder.sv
// first_bit_finder: combinational first-set-bit locator (mask in; onehot, index, found out; MSB_FIRST picks scan direction)
module first_bit_finder #(
  parameter int WIDTH = 16,
  parameter bit MSB_FIRST = 0,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             found
);
  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++)
      if (mask[MSB_FIRST ? i : WIDTH-1-i]) index = IDX_W'(MSB_FIRST ? i : WIDTH-1-i);
    found = |mask;
    onehot = found ? (WIDTH'(1) << index) : '0;
  end
endmodule

// File: rtl/mask_serializer.sv
// mask_serializer: walks a request mask (data_i/data_val_i/data_rdy_o) into one-hot words (onehot_o/index_o/last_o/data_val_o/data_rdy_i), clk_i, sync active-low srst_n_i
module mask_serializer
  import mask_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit MSB_FIRST = 0,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
);
  state_t state, state_n;
  logic [WIDTH-1:0] pend, pend_n, oh;
  logic [IDX_W-1:0] ix;
  logic found, busy, xfer, acc;
  first_bit_finder #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_fbf (
    .mask(pend), .onehot(oh), .index(ix), .found(found)
  );
  assign busy = state == ST_BUSY;
  assign data_val_o = busy && found;
  assign onehot_o = data_val_o ? oh : '0;
  assign index_o = data_val_o ? ix : '0;
  assign last_o = data_val_o && ((pend & ~oh) == '0);
  assign data_rdy_o = srst_n_i && (!busy || (data_val_o && last_o && data_rdy_i));
  assign xfer = data_val_o && data_rdy_i;
  assign acc = data_val_i && data_rdy_o;
  always_comb begin
    pend_n = acc ? data_i : xfer ? (pend & ~oh) : pend;
    state_n = acc ? (|data_i ? ST_BUSY : ST_IDLE) : (xfer && last_o) ? ST_IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state <= ST_IDLE;
      pend <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
    end
  end
endmodule

// File: tb/tb_mask_serializer.sv
// tb_mask_serializer: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_mask_serializer;
  localparam int W = 8;
  localparam int IW = 3;
  typedef struct packed {logic [W-1:0] oh; logic [IW-1:0] ix; logic la;} word_t;
  logic clk_i = 0, srst_n_i = 0, data_val_i = 0, data_rdy_i = 1;
  logic [W-1:0] data_i = '0;
  logic [W-1:0] oh_l, oh_m;
  logic [IW-1:0] ix_l, ix_m;
  logic la_l, la_m, vo_l, vo_m, ro_l, ro_m;
  word_t q_l[$], q_m[$];
  word_t hd_l, hd_m;
  logic st_l = 0, st_m = 0;
  int checks = 0, failures = 0, cnt_l = 0, cnt_m = 0;
  always #5 clk_i = ~clk_i;
  mask_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .data_i(data_i), .data_val_i(data_val_i), .data_rdy_o(ro_l),
    .onehot_o(oh_l), .index_o(ix_l), .last_o(la_l), .data_val_o(vo_l), .data_rdy_i(data_rdy_i)
  );
  mask_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .data_i(data_i), .data_val_i(data_val_i), .data_rdy_o(ro_m),
    .onehot_o(oh_m), .index_o(ix_m), .last_o(la_m), .data_val_o(vo_m), .data_rdy_i(data_rdy_i)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask
  task automatic push_mask(input logic [W-1:0] m);
    int n, k;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(m[i]);
    k = 0;
    for (int i = 0; i < W; i++)
      if (m[i]) begin
        k++;
        q_l.push_back(word_t'{oh: W'(1) << i, ix: IW'(i), la: k == n});
      end
    k = 0;
    for (int i = W - 1; i >= 0; i--)
      if (m[i]) begin
        k++;
        q_m.push_back(word_t'{oh: W'(1) << i, ix: IW'(i), la: k == n});
      end
  endtask
  always @(negedge clk_i) begin
    word_t e;
    if (st_l) chk("lsb_stall_hold", {vo_l, oh_l, ix_l, la_l}, {1'b1, hd_l});
    if (st_m) chk("msb_stall_hold", {vo_m, oh_m, ix_m, la_m}, {1'b1, hd_m});
    if (!vo_l) chk("lsb_idle_zero", {oh_l, ix_l, la_l}, 0);
    if (!vo_m) chk("msb_idle_zero", {oh_m, ix_m, la_m}, 0);
    if (vo_l && data_rdy_i) begin
      cnt_l++;
      if (q_l.size() == 0) chk("lsb_unexpected_word", {oh_l, ix_l, la_l}, 0);
      else begin
        e = q_l.pop_front();
        chk("lsb_word", {oh_l, ix_l, la_l}, e);
      end
    end
    if (vo_m && data_rdy_i) begin
      cnt_m++;
      if (q_m.size() == 0) chk("msb_unexpected_word", {oh_m, ix_m, la_m}, 0);
      else begin
        e = q_m.pop_front();
        chk("msb_word", {oh_m, ix_m, la_m}, e);
      end
    end
    st_l = vo_l && !data_rdy_i && srst_n_i;
    st_m = vo_m && !data_rdy_i && srst_n_i;
    hd_l = {oh_l, ix_l, la_l};
    hd_m = {oh_m, ix_m, la_m};
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  // Holds data_val_i until accept, returns the number of wait cycles.
  task automatic send(input logic [W-1:0] m, output int t);
    t = 0;
    data_i = m;
    data_val_i = 1;
    @(negedge clk_i);
    while (!ro_l && t < 200) begin
      t++;
      @(negedge clk_i);
    end
    chk("accept_timeout", t < 200, 1);
    push_mask(m);
    tick();
    data_val_i = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q_l.size() != 0 || q_m.size() != 0) && t < 200) begin
      t++;
      tick();
    end
    chk("drain_timeout", t < 200, 1);
    tick();
  endtask
  initial begin
    int t, c0;
    repeat (3) tick();
    @(negedge clk_i);
    chk("reset_rdy_low", {ro_l, ro_m}, 0);
    chk("reset_val_low", {vo_l, vo_m}, 0);
    srst_n_i = 1;
    @(negedge clk_i);
    chk("post_reset_rdy", {ro_l, ro_m}, 2'b11);
    tick();
    send(8'b1010_0110, t);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("a6_rdy_cycle%0d", c), {ro_l, ro_m}, (c == 4) ? 2'b11 : 2'b00);
      chk($sformatf("a6_val_cycle%0d", c), {vo_l, vo_m}, 2'b11);
      tick();
    end
    @(negedge clk_i);
    chk("a6_done_val", {vo_l, vo_m}, 0);
    tick();
    send(8'h01, t);
    chk("b2b_first_wait", t, 0);
    send(8'h81, t);
    chk("b2b_no_bubble", t, 0);
    drain();
    send(8'h00, t);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("zero_mask_val", {vo_l, vo_m}, 0);
      chk("zero_mask_rdy", {ro_l, ro_m}, 2'b11);
      tick();
    end
    send(8'h10, t);
    drain();
    c0 = cnt_l;
    send(8'hFF, t);
    t = 0;
    while (q_l.size() != 0 && t < 500) begin
      t++;
      data_rdy_i = 1'($urandom_range(0, 1));
      tick();
    end
    data_rdy_i = 1;
    chk("stall_walk_timeout", t < 500, 1);
    drain();
    chk("ff_transfer_count", cnt_l - c0, 8);
    send(8'hFF, t);
    tick();
    tick();
    srst_n_i = 0;
    @(negedge clk_i);
    chk("rst_mid_rdy", {ro_l, ro_m}, 0);
    chk("rst_mid_val_before", {vo_l, vo_m}, 2'b11);
    tick();
    @(negedge clk_i);
    chk("rst_mid_val_after", {vo_l, vo_m}, 0);
    chk("rst_mid_rdy_held", {ro_l, ro_m}, 0);
    q_l.delete();
    q_m.delete();
    tick();
    srst_n_i = 1;
    @(negedge clk_i);
    chk("rst_release_rdy", {ro_l, ro_m}, 2'b11);
    tick();
    c0 = cnt_l;
    send(8'h03, t);
    drain();
    chk("after_rst_count", cnt_l - c0, 2);
    chk("lsb_queue_empty", q_l.size(), 0);
    chk("msb_queue_empty", q_m.size(), 0);
    chk("count_match", cnt_l, cnt_m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mask_serializer.md
# mask_serializer

Serializes a WIDTH-bit request mask into a stream of one-hot words, one set bit per transfer, with the bit index and a last flag. Sits directly upstream of the priority-encoding stage and of any per-request consumer. It turns a multi-bit mask into individual grants instead of reporting only the extreme set bits. Valid/ready handshakes on both sides let back-pressure stall the walk without losing bits.

## Interface
- WIDTH, 16: mask width; legal range 2..64.
- MSB_FIRST, 0: 0 emits the lowest set bit first; 1 emits the highest set bit first.
- IDX_W, $clog2(WIDTH): derived index width; not overridden.

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- srst_n_i  in  1  synchronous reset, active-low. One clock, clk_i; reset srst_n_i is synchronous and active-low.
- data_i  in  WIDTH  request mask.
- data_val_i  in  1  data_i valid.
- data_rdy_o  out  1  block accepts data_i this cycle.
- onehot_o  out  WIDTH  current one-hot word.
- index_o  out  IDX_W  bit position of onehot_o.
- last_o  out  1  current word is the final set bit of the mask.
- data_val_o  out  1  onehot_o/index_o/last_o valid.
- data_rdy_i  in  1  downstream accepts the current word.

## Operation
- States: IDLE and BUSY. The block holds mask register `pend`.
- Accept condition: data_val_i && data_rdy_o.
- data_rdy_o = (state==IDLE) || (data_val_o && last_o && data_rdy_i). This allows back-to-back masks with no bubble.
- Accepting a nonzero mask:
  - Load `pend` with data_i.
  - Next state is BUSY.
- Accepting a zero mask:
  - The mask is consumed and dropped; nothing is emitted.
  - Next state is IDLE.
  - If the zero mask arrives on the reload path, state goes to IDLE.
- In BUSY:
  - data_val_o=1.
  - onehot_o is the first set bit of `pend` per MSB_FIRST.
  - index_o is that bit's position.
  - last_o = ((pend & ~onehot_o) == 0).
- Transfer (data_val_o && data_rdy_i):
  - `pend` <= pend & ~onehot_o.
  - If last_o, go to IDLE, or reload on a simultaneous accept.
- Stall (data_rdy_i=0): all outputs and `pend` hold stable. data_val_o never drops without a transfer.
- While data_val_o=0, onehot_o=0, index_o=0 and last_o=0.
- No combinational path exists from data_i to any output. There is a combinational path from data_rdy_i to data_rdy_o only.

## Timing
- Reset (srst_n_i=0 at an edge):
  - state becomes IDLE and `pend` becomes 0.
  - data_val_o=0, onehot_o=0, index_o=0, last_o=0.
  - data_rdy_o is forced 0 while srst_n_i is low and returns to 1 on the first cycle after release.
  - Reset mid-walk discards the remaining bits.
- Latency: a mask accepted at edge N presents its first word in cycle N+1.
- Throughput with data_rdy_i tied 1:
  - A mask with k set bits occupies exactly k cycles.
  - The next mask is accepted in the cycle of the last word.
  - Full-ones mask: WIDTH consecutive words.
- Handshake: data_val_i held without data_rdy_o must be tolerated; data_i is sampled only on accept.

## Structure
- Package mask_serializer_pkg holds the state enum (ST_IDLE, ST_BUSY).
- Sub-module first_bit_finder, purely combinational, parameters WIDTH and MSB_FIRST:
  - Inputs: a mask.
  - Outputs: onehot, index and found.
  - It is instantiated once on `pend`.
- The top level holds the FSM, `pend` and the handshake logic.

## Test plan
- WIDTH=8, MSB_FIRST=0, mask 8'b1010_0110, data_rdy_i=1 -> words 0x02/1, 0x04/2, 0x20/5, 0x80/7 on consecutive cycles; last_o only on 0x80.
- Same mask with MSB_FIRST=1 -> 0x80/7, 0x20/5, 0x04/2, 0x02/1; data_rdy_o is 0 for cycles 1–3 and 1 in cycle 4.
- Masks 8'h01 then 8'h81 with data_val_i held -> 0x01(last), 0x01, 0x80(last) with no bubble between masks; the single-bit mask has last_o in its only cycle.
- Zero mask 8'h00 accepted -> data_val_o stays 0 and data_rdy_o stays 1; next mask 8'h10 -> single word 0x10/4 with last_o.
- Random data_rdy_i toggling on mask 8'hFF -> outputs are stable during stalls; exactly 8 transfers in ascending index order.
- srst_n_i low during the 3rd word of 8'hFF -> data_val_o 0 next cycle and data_rdy_o 0 during reset; after release, a new mask 8'h03 yields 0x01, 0x02(last) only.
